// File: rtl/vru_pkg.sv
// Shared types and defaults for the vector reduce/accumulate unit.
// Mode codes, lane type, chain-id width and group size.
package vru_pkg;

  localparam int VRU_N      = 8;
  localparam int VRU_M      = 2;
  localparam int VRU_DW     = 32;
  localparam int VRU_CHAINS = 4;
  localparam int VRU_CW     = (VRU_CHAINS > 1) ? $clog2(VRU_CHAINS) : 1;
  localparam int VRU_GS     = VRU_N / VRU_M;

  typedef enum logic [2:0] {
    PASS      = 3'd0,
    SUM_ALL   = 3'd1,
    SUM_GROUP = 3'd2,
    ACC_ALL   = 3'd3,
    ACC_GROUP = 3'd4
  } mode_e;

  typedef logic [VRU_DW-1:0] lane_t;

endpackage

// File: rtl/vector_reduce_accumulate_unit_if.sv
// Config port, input beat and output beat of the reduce/accumulate unit.
// master drives config/input and observes output; slave is the unit.
interface vector_reduce_accumulate_unit_if
  import vru_pkg::*;
#(
  parameter int N          = VRU_N,
  parameter int DATA_WIDTH = VRU_DW,
  parameter int CW         = VRU_CW
) ();

  logic                         cfg_we;
  logic [CW-1:0]                cfg_chain;
  logic [2:0]                   cfg_mode;
  logic                         valid_in;
  logic                         eof_in;
  logic [CW-1:0]                chainId_in;
  logic [N-1:0][DATA_WIDTH-1:0] vector_in;
  logic                         valid_out;
  logic                         eof_out;
  logic [CW-1:0]                chainId_out;
  logic [N-1:0][DATA_WIDTH-1:0] vector_out;

  modport master (
    output cfg_we, cfg_chain, cfg_mode,
    output valid_in, eof_in, chainId_in, vector_in,
    input  valid_out, eof_out, chainId_out, vector_out
  );

  modport slave (
    input  cfg_we, cfg_chain, cfg_mode,
    input  valid_in, eof_in, chainId_in, vector_in,
    output valid_out, eof_out, chainId_out, vector_out
  );

endinterface

// File: rtl/group_adder_tree.sv
// Combinational M group sums of an N-lane vector, plus their total.
// Ports: vec (N lanes in), grp (M sums out), total (sum of grp).
module group_adder_tree #(
  parameter int N          = 8,
  parameter int M          = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic [N-1:0][DATA_WIDTH-1:0] vec,
  output logic [M-1:0][DATA_WIDTH-1:0] grp,
  output logic [DATA_WIDTH-1:0]        total
);

  localparam int GS = N / M;

  always_comb begin
    grp = '0;
    for (int g = 0; g < M; g++) begin
      for (int i = 0; i < GS; i++) begin
        grp[g] = grp[g] + vec[g*GS+i];
      end
    end
  end

  always_comb begin
    total = '0;
    for (int g = 0; g < M; g++) begin
      total = total + grp[g];
    end
  end

endmodule

// File: rtl/vector_reduce_accumulate_unit.sv
// Two-stage per-chain vector reducer / frame accumulator.
// Ports: clk, rst_n (async low), bus (config, input and output beats).
module vector_reduce_accumulate_unit
  import vru_pkg::*;
#(
  parameter int N          = VRU_N,
  parameter int M          = VRU_M,
  parameter int DATA_WIDTH = VRU_DW,
  parameter int MAX_CHAINS = VRU_CHAINS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  vector_reduce_accumulate_unit_if.slave  bus
);

  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
  typedef logic [M-1:0][DATA_WIDTH-1:0] grp_t;

  logic [MAX_CHAINS-1:0][2:0] mode_q;
  logic [MAX_CHAINS-1:0][M-1:0][DATA_WIDTH-1:0] acc;

  grp_t                  grp;
  logic [DATA_WIDTH-1:0] total;

  logic                  s1_valid;
  logic                  s1_eof;
  logic [CW-1:0]         s1_chain;
  logic [2:0]            s1_mode;
  vec_t                  s1_vec;
  grp_t                  s1_grp;
  logic [DATA_WIDTH-1:0] s1_total;

  logic                  is_acc;
  logic                  out_fire;
  logic                  acc_upd;
  grp_t                  sums;
  grp_t                  acc_rd;
  grp_t                  acc_nxt;
  vec_t                  res;

  group_adder_tree #(
    .N          (N),
    .M          (M),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tree (
    .vec   (bus.vector_in),
    .grp   (grp),
    .total (total)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
    end else if (bus.cfg_we) begin
      mode_q[bus.cfg_chain] <= bus.cfg_mode;
    end
  end

  // Mode is read before this edge's config write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_eof   <= 1'b0;
      s1_chain <= '0;
      s1_mode  <= '0;
      s1_vec   <= '0;
      s1_grp   <= '0;
      s1_total <= '0;
    end else begin
      s1_valid <= bus.valid_in;
      s1_eof   <= bus.eof_in;
      s1_chain <= bus.chainId_in;
      s1_mode  <= mode_q[bus.chainId_in];
      s1_vec   <= bus.vector_in;
      s1_grp   <= grp;
      s1_total <= total;
    end
  end

  assign is_acc   = (s1_mode == ACC_ALL) || (s1_mode == ACC_GROUP);
  assign out_fire = s1_valid && (!is_acc || s1_eof);
  assign acc_upd  = s1_valid && is_acc;
  assign acc_rd   = acc[s1_chain];

  always_comb begin
    sums = '0;
    if (s1_mode == ACC_ALL) begin
      sums[0] = s1_total;
    end else begin
      sums = s1_grp;
    end
  end

  always_comb begin
    acc_nxt = '0;
    for (int g = 0; g < M; g++) begin
      acc_nxt[g] = acc_rd[g] + sums[g];
    end
  end

  always_comb begin
    res = '0;
    unique case (1'b1)
      s1_mode == SUM_ALL: begin
        res[0] = s1_total;
      end
      s1_mode == SUM_GROUP: begin
        for (int g = 0; g < M; g++) res[g] = s1_grp[g];
      end
      is_acc: begin
        for (int g = 0; g < M; g++) res[g] = acc_nxt[g];
      end
      default: res = s1_vec;
    endcase
  end

  // A config write to a chain clears its accumulator and beats any
  // stage-2 update landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        if (bus.cfg_we && bus.cfg_chain == CW'(c)) begin
          acc[c] <= '0;
        end else if (acc_upd && s1_chain == CW'(c)) begin
          acc[c] <= s1_eof ? '0 : acc_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_out   <= 1'b0;
      bus.eof_out     <= 1'b0;
      bus.chainId_out <= '0;
      bus.vector_out  <= '0;
    end else begin
      bus.valid_out <= out_fire;
      bus.eof_out   <= out_fire && s1_eof;
      if (out_fire) begin
        bus.chainId_out <= s1_chain;
        bus.vector_out  <= res;
      end
    end
  end

endmodule

// File: tb/tb_vector_reduce_accumulate_unit.sv
// Scoreboard bench for vector_reduce_accumulate_unit.
// Directed beats push expectations; a negedge monitor pops and compares.
module tb_vector_reduce_accumulate_unit;
  import vru_pkg::*;

  typedef logic [7:0][31:0] vec_t;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  ch;
    logic        eof;
    vec_t        v;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int          n_cmp;
  int          n_fail;
  exp_t        q[$];

  vector_reduce_accumulate_unit_if #(
    .N(8), .DATA_WIDTH(32), .CW(2)
  ) bus ();

  vector_reduce_accumulate_unit #(
    .N(8), .M(2), .DATA_WIDTH(32), .MAX_CHAINS(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t v18();
    vec_t v;
    for (int i = 0; i < 8; i++) v[i] = 32'(i + 1);
    return v;
  endfunction

  function automatic vec_t fill(input logic [31:0] x);
    vec_t v;
    for (int i = 0; i < 8; i++) v[i] = x;
    return v;
  endfunction

  function automatic vec_t z2(input logic [31:0] a,
                              input logic [31:0] b);
    vec_t v;
    v = '0;
    v[0] = a;
    v[1] = b;
    return v;
  endfunction

  task automatic drive(input logic we, input logic [1:0] cch,
                       input logic [2:0] cm, input logic vld,
                       input logic eof, input logic [1:0] ch,
                       input vec_t v);
    @(negedge clk);
    bus.cfg_we     = we;
    bus.cfg_chain  = cch;
    bus.cfg_mode   = cm;
    bus.valid_in   = vld;
    bus.eof_in     = eof;
    bus.chainId_in = ch;
    bus.vector_in  = v;
  endtask

  task automatic push(input logic [1:0] ch, input logic eof,
                      input vec_t ev);
    exp_t e;
    e.cyc = cyc + 2;
    e.ch  = ch;
    e.eof = eof;
    e.v   = ev;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [2:0] m);
    drive(1, ch, m, 0, 0, 0, '0);
  endtask

  task automatic beat(input logic [1:0] ch, input logic eof,
                      input vec_t v, input logic out,
                      input vec_t ev);
    drive(0, 0, 0, 1, eof, ch, v);
    if (out) push(ch, eof, ev);
  endtask

  task automatic beat_cfg(input logic [1:0] ch, input logic [2:0] m,
                          input logic eof, input vec_t v,
                          input vec_t ev);
    drive(1, ch, m, 1, eof, ch, v);
    push(ch, eof, ev);
  endtask

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) idle(1);
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d beats never appeared, want 0",
               q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.valid_out) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected: got ch=%0d vec=%h, want none",
                 bus.chainId_out, bus.vector_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.ch != bus.chainId_out ||
            e.eof != bus.eof_out || e.v != bus.vector_out) begin
          n_fail++;
          $display("FAIL beat: got cyc=%0d ch=%0d eof=%0b v=%h want cyc=%0d ch=%0d eof=%0b v=%h",
                   cyc, bus.chainId_out, bus.eof_out, bus.vector_out,
                   e.cyc, e.ch, e.eof, e.v);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.cfg_we     = 0;
    bus.cfg_chain  = 0;
    bus.cfg_mode   = 0;
    bus.valid_in   = 0;
    bus.eof_in     = 0;
    bus.chainId_in = 0;
    bus.vector_in  = '0;
    repeat (3) @(negedge clk);
    chk("rst valid_out", 256'(bus.valid_out), 256'(0));
    chk("rst eof_out", 256'(bus.eof_out), 256'(0));
    chk("rst chainId_out", 256'(bus.chainId_out), 256'(0));
    chk("rst vector_out", 256'(bus.vector_out), 256'(0));
    rst_n = 1'b1;
    idle(3);
    chk("idle valid_out", 256'(bus.valid_out), 256'(0));

    beat(0, 0, v18(), 1, v18());
    idle(3);

    cfg(1, SUM_ALL);
    cfg(2, SUM_GROUP);
    cfg(3, ACC_GROUP);
    beat(1, 0, v18(), 1, z2(36, 0));
    beat(2, 0, v18(), 1, z2(10, 26));
    idle(2);

    beat(3, 0, v18(), 0, '0);
    beat(3, 0, v18(), 0, '0);
    beat(3, 1, v18(), 1, z2(30, 78));
    beat(3, 1, v18(), 1, z2(10, 26));
    idle(3);

    cfg(0, ACC_ALL);
    cfg(1, ACC_ALL);
    beat(0, 0, fill(1), 0, '0);
    beat(1, 0, fill(2), 0, '0);
    beat(0, 0, fill(1), 0, '0);
    beat(1, 1, fill(2), 1, z2(32, 0));
    beat(0, 1, fill(1), 1, z2(24, 0));
    idle(3);

    cfg(1, SUM_ALL);
    beat(1, 0, fill(32'hFFFF_FFFF), 1, z2(32'hFFFF_FFF8, 0));
    idle(3);

    beat(0, 0, fill(1), 0, '0);
    beat(0, 0, fill(1), 0, '0);
    cfg(0, ACC_ALL);
    beat(0, 1, fill(3), 1, z2(24, 0));
    idle(3);

    beat_cfg(2, PASS, 0, v18(), z2(10, 26));
    beat(2, 1, v18(), 1, v18());
    idle(3);
    drain();

    beat(3, 0, v18(), 0, '0);
    idle(3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async valid_out", 256'(bus.valid_out), 256'(0));
    chk("async eof_out", 256'(bus.eof_out), 256'(0));
    chk("async chainId_out", 256'(bus.chainId_out), 256'(0));
    chk("async vector_out", 256'(bus.vector_out), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cfg(3, ACC_GROUP);
    beat(3, 0, v18(), 0, '0);
    beat(3, 1, fill(1), 1, z2(14, 30));
    idle(4);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_fail);
    $finish;
  end

endmodule
